// File: rtl/siso_loop_ctrl.sv
// -----------------------------------------------------------------------------
// siso_loop_ctrl
//
// Sequencing controller for a serial-in/serial-out shift chain. A parallel
// word is accepted over a valid/ready handshake and driven LSB-first into the
// chain's serial input. Zeros are then pushed through the chain to flush it.
// While the word shifts and flushes, the chain's tail bit is sampled back into
// a receive word. When the transfer ends, the received word is presented with
// a loopback mismatch flag and a saturating mismatch count.
//
// Ports
//   clk        in   single clock, rising edge
//   rst        in   synchronous active-high reset
//   in_valid   in   parallel word offered
//   in_ready   out  controller idle and able to accept a word
//   in_data    in   word to send (WIDTH)
//   si         out  registered serial bit to the chain input
//   so_last    in   chain tail bit (output of stage DEPTH)
//   out_valid  out  captured word available
//   out_ready  in   consumer takes the captured word
//   out_data   out  captured word (WIDTH)
//   err        out  captured word differs from sent word (valid with out_valid)
//   err_cnt    out  saturating count of mismatched words (8)
//   busy       out  controller not idle
// -----------------------------------------------------------------------------
module siso_loop_ctrl #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             si,
    input  logic             so_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             err,
    output logic [7:0]       err_cnt,
    output logic             busy
);

    // The cycle counter runs from the first SHIFT cycle through the last
    // FLUSH cycle; it is sized so it never wraps inside a transfer.
    localparam int CNT_MAX = ((WIDTH > DEPTH) ? WIDTH : DEPTH) + WIDTH;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] LAST_FLUSH = CNT_W'(WIDTH + DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state_reg,   state_next;
    logic [WIDTH-1:0]   tx_reg,      tx_next;
    logic [WIDTH-1:0]   rx_reg,      rx_next;
    logic [CNT_W-1:0]   cnt_reg,     cnt_next;
    logic               si_reg,      si_next;
    logic               err_reg,     err_next;
    logic [7:0]         err_cnt_reg, err_cnt_next;

    // Receive word with this cycle's tail sample merged in. Bit i of the sent
    // word leaves the chain DEPTH cycles after it entered, i.e. in cycle
    // DEPTH+i counted from the first SHIFT cycle. Nothing earlier is sampled,
    // so stale chain contents from before the transfer never reach rx.
    logic               transfer_active;
    logic [WIDTH-1:0]   capture_en;
    logic [WIDTH-1:0]   rx_cap;

    assign transfer_active = (state_reg == SHIFT) || (state_reg == FLUSH);

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_capture
            assign capture_en[gi] = transfer_active && (cnt_reg == CNT_W'(DEPTH + gi));
            assign rx_cap[gi]     = capture_en[gi] ? so_last : rx_reg[gi];
        end
    endgenerate

    // Next-state and datapath logic
    always_comb begin
        state_next   = state_reg;
        tx_next      = tx_reg;
        rx_next      = rx_reg;
        cnt_next     = cnt_reg;
        si_next      = 1'b0;
        err_next     = err_reg;
        err_cnt_next = err_cnt_reg;

        case (state_reg)
            IDLE: begin
                // in_ready is 1 throughout IDLE, so in_valid alone is a handshake.
                if (in_valid) begin
                    tx_next    = in_data;
                    rx_next    = '0;
                    cnt_next   = '0;
                    // si is registered: load bit 0 so it is on the wire in the
                    // first SHIFT cycle.
                    si_next    = in_data[0];
                    state_next = SHIFT;
                end
            end

            SHIFT: begin
                rx_next  = rx_cap;
                cnt_next = cnt_reg + 1'b1;
                // Preload the bit for the following SHIFT cycle; after the
                // last data bit the chain is fed zeros.
                for (int i = 1; i < WIDTH; i++) begin
                    if (cnt_reg == CNT_W'(i - 1)) begin
                        si_next = tx_reg[i];
                    end
                end
                if (cnt_reg == LAST_SHIFT) begin
                    state_next = FLUSH;
                end
            end

            FLUSH: begin
                rx_next  = rx_cap;
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == LAST_FLUSH) begin
                    // The final tail sample lands on this same edge, so the
                    // compare uses the merged word rather than rx_reg.
                    err_next = (rx_cap != tx_reg);
                    if ((rx_cap != tx_reg) && (err_cnt_reg != 8'hFF)) begin
                        err_cnt_next = err_cnt_reg + 8'd1;
                    end
                    state_next = DONE;
                end
            end

            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            tx_reg      <= '0;
            rx_reg      <= '0;
            cnt_reg     <= '0;
            si_reg      <= 1'b0;
            err_reg     <= 1'b0;
            err_cnt_reg <= 8'd0;
        end else begin
            state_reg   <= state_next;
            tx_reg      <= tx_next;
            rx_reg      <= rx_next;
            cnt_reg     <= cnt_next;
            si_reg      <= si_next;
            err_reg     <= err_next;
            err_cnt_reg <= err_cnt_next;
        end
    end

    // Handshake outputs are decoded from state only, so there is no
    // combinational path from in_valid/out_ready to in_ready/out_valid.
    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign busy      = (state_reg != IDLE);
    assign si        = si_reg;
    assign out_data  = rx_reg;
    assign err       = err_reg;
    assign err_cnt   = err_cnt_reg;

endmodule

// File: tb/tb_siso_loop_ctrl.sv
// -----------------------------------------------------------------------------
// tb_siso_loop_ctrl
//
// Drives siso_loop_ctrl with a DEPTH-stage shift chain attached (optionally
// inverting the tail bit). A scoreboard queue holds the expected captured
// word, mismatch flag, error count and acceptance edge for each accepted word;
// a monitor process pops and compares whenever out_valid appears.
// -----------------------------------------------------------------------------
module tb_siso_loop_ctrl;

    localparam int W = 4;
    localparam int D = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_data;
    logic           si;
    logic           so_last;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;
    logic           err;
    logic [7:0]     err_cnt;
    logic           busy;

    always #5 clk = ~clk;

    siso_loop_ctrl #(.WIDTH(W), .DEPTH(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .si        (si),
        .so_last   (so_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .err       (err),
        .err_cnt   (err_cnt),
        .busy      (busy)
    );

    // Attached chain: D flops, tail optionally inverted to force mismatches.
    logic [D-1:0] chain;
    logic         inv;
    always @(posedge clk) chain <= {chain[D-2:0], si};
    assign so_last = chain[D-1] ^ inv;

    int cyc;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [W-1:0] data;
        logic         err;
        logic [7:0]   cnt;
        int           edge_no;
    } exp_t;

    exp_t q[$];
    int   exp_cnt = 0;

    bit hold_ready = 1'b0;
    bit rand_ready = 1'b0;
    bit active     = 1'b0;
    exp_t cur;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pops on each new out_valid, checks latency and contents, and
    // checks the word stays stable while the consumer stalls.
    always @(negedge clk) begin
        if (rst) begin
            active = 1'b0;
        end else if (out_valid) begin
            if (!active) begin
                if (q.size() == 0) begin
                    check("unexpected_out_valid", 32'(out_valid), 0);
                end else begin
                    cur    = q.pop_front();
                    active = 1'b1;
                    $display("out word %b err %0d err_cnt %0d at cycle %0d", out_data, err, err_cnt, cyc);
                    check("latency", cyc, cur.edge_no + 8);
                    check("err_cnt", 32'(err_cnt), 32'(cur.cnt));
                end
            end
            if (active) begin
                check("out_data", 32'(out_data), 32'(cur.data));
                check("err", 32'(err), 32'(cur.err));
                check("in_ready_in_done", 32'(in_ready), 0);
            end
        end
        out_ready = hold_ready ? 1'b0 : (rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
        if (out_valid && out_ready) active = 1'b0;
    end

    task automatic check_reset_outputs();
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_si", 32'(si), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_err", 32'(err), 0);
        check("rst_err_cnt", 32'(err_cnt), 0);
        check("rst_busy", 32'(busy), 0);
    endtask

    // Called at a negedge; returns at a negedge.
    task automatic do_reset(input int n);
        rst = 1'b1;
        in_valid = 1'b0;
        q.delete();
        exp_cnt = 0;
        repeat (n) @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 1);
        check("post_rst_busy", 32'(busy), 0);
    endtask

    // Offer one word; on acceptance push the expectation and check the si
    // stream over the SHIFT and FLUSH cycles. Called and returns at a negedge.
    task automatic send(input logic [W-1:0] d, input bit inv_w);
        int   n;
        exp_t e;
        inv      = inv_w;
        in_data  = d;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("accept_timeout", 32'(in_ready), 1);
            in_valid = 1'b0;
            return;
        end
        e.data = inv_w ? ~d : d;
        e.err  = (e.data != d);
        if (e.err && exp_cnt < 255) exp_cnt++;
        e.cnt     = 8'(exp_cnt);
        e.edge_no = cyc + 1;
        q.push_back(e);
        $display("send %b inv %0d at edge %0d", d, inv_w, e.edge_no);
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < W + D; k++) begin
            check("si", 32'(si), (k < W) ? 32'(d[k]) : 0);
            if (k == 0) begin
                check("busy_shift", 32'(busy), 1);
                check("in_ready_shift", 32'(in_ready), 0);
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(in_ready && q.size() == 0 && !out_valid) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 32'(in_ready && q.size() == 0 && !out_valid), 1);
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        inv      = 1'b0;
        @(negedge clk);
        do_reset(3);

        // Reset held 2 cycles while idle
        repeat (2) @(negedge clk);
        do_reset(2);

        // Plain loopback
        send(4'b0110, 1'b0);
        wait_idle();

        // Inverted tail
        send(4'b1010, 1'b1);
        wait_idle();

        // Backpressure with an ignored in_valid pulse
        hold_ready = 1'b1;
        send(4'b0011, 1'b0);
        for (int n = 0; n < 20 && !out_valid; n++) @(negedge clk);
        check("bp_out_valid", 32'(out_valid), 1);
        for (int c = 0; c < 5; c++) begin
            check("bp_in_ready", 32'(in_ready), 0);
            check("bp_out_valid_held", 32'(out_valid), 1);
            in_valid = (c == 2);
            in_data  = 4'b1111;
            @(negedge clk);
        end
        in_valid   = 1'b0;
        hold_ready = 1'b0;
        wait_idle();
        send(4'b1100, 1'b0);
        wait_idle();

        // Reset mid-SHIFT after 2 bits
        in_data  = 4'b0111;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        do_reset(1);
        for (int c = 0; c < 12; c++) begin
            check("no_out_after_rst", 32'(out_valid), 0);
            @(negedge clk);
        end
        send(4'b1001, 1'b0);
        wait_idle();

        // Randomized words, random inversion, random consumer stalls
        rand_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            send(4'($urandom), 1'($urandom_range(0, 1)));
        end
        wait_idle();
        rand_ready = 1'b0;

        // Saturation
        for (int i = 0; i < 300; i++) begin
            send(4'($urandom), 1'b1);
        end
        wait_idle();
        check("err_cnt_saturated", 32'(err_cnt), 255);
        check("queue_drained", 32'(q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/siso_loop_ctrl.md
# siso_loop_ctrl

Sequencing controller for the 4-bit serial-in/serial-out shift chain. It accepts a parallel word over a valid/ready handshake and drives it LSB-first into the chain's serial input. It flushes the chain and reassembles the word from the chain's tail bit, then presents the captured word with a loopback mismatch flag and a saturating error count. It sits between the parallel test/config interface and the serial chain and is the only driver of the chain's `si`.

## Interface
- `WIDTH`, 4: bits per word.
- `DEPTH`, 4: stages in the attached shift chain (tail lag in cycles).
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  parallel word offered.
- `in_ready`  out  1  controller can accept a word.
- `in_data`  in  WIDTH  word to send.
- `si`  out  1  registered serial bit to chain input.
- `so_last`  in  1  chain tail bit (output of stage DEPTH).
- `out_valid`  out  1  captured word available.
- `out_ready`  in  1  consumer takes captured word.
- `out_data`  out  WIDTH  captured word.
- `err`  out  1  captured word differs from sent word; meaningful while `out_valid`.
- `err_cnt`  out  8  saturating count of mismatched words.
- `busy`  out  1  state != IDLE.

## Operation
- FSM states: IDLE, SHIFT, FLUSH, DONE.
- IDLE:
  - `in_ready`=1, `si`=0.
  - On `in_valid && in_ready`, latch `in_data` into the tx word, clear the bit counter and rx register, and go to SHIFT.
  - `in_valid` without acceptance has no effect.
- SHIFT, WIDTH cycles:
  - In the k-th SHIFT cycle (k=0..WIDTH-1), `si` = tx[k].
  - Go to FLUSH after k=WIDTH-1.
- FLUSH, DEPTH cycles: `si`=0.
- Capture runs across SHIFT and FLUSH, counted from the first SHIFT cycle S:
  - In cycle S+DEPTH+i (i=0..WIDTH-1), sample `so_last` into rx[i].
  - Stale chain contents before S are never sampled, so the chain needs no reset.
- End of the last FLUSH cycle (S+WIDTH+DEPTH-1):
  - `err` = (rx != tx) is registered.
  - If `err`, `err_cnt` increments and saturates at 255.
  - Go to DONE.
- DONE:
  - `out_valid`=1; `out_data`=rx and `err` are held stable.
  - On `out_valid && out_ready`, go to IDLE.
  - `in_ready`=0 in all states except IDLE; `in_valid` is ignored while busy.
- Counters are sized for max(WIDTH, DEPTH)+WIDTH and must not wrap during a transfer.
- Reset, at any time including mid-SHIFT/FLUSH/DONE:
  - Next state IDLE; the in-flight word is discarded with no `out_valid`.
  - `si`=0, `out_valid`=0, `out_data`=0, `err`=0, `err_cnt`=0.
  - `in_ready`=1 in the first cycle after reset.

## Timing
- Reset values: `in_ready`=1, `si`=0, `out_valid`=0, `out_data`=0, `err`=0, `err_cnt`=0, `busy`=0.
- Accept edge E: first SHIFT cycle S is the cycle after E; `si`=tx[0] during S.
- Chain relation (DEPTH flops): `so_last` in cycle t = `si` in cycle t-DEPTH.
- `out_valid` rises in cycle S+WIDTH+DEPTH. Default parameters: 8 cycles after the accept edge.
- `out_valid` is held until the handshake edge. `in_ready` rises in the following cycle.
- Minimum word period: WIDTH+DEPTH+2 cycles (1 IDLE + SHIFT + FLUSH + 1 DONE with `out_ready`=1).
- No combinational path from `in_valid`/`out_ready` to `in_ready`/`out_valid`; all outputs are registered or decoded from state only.

## Test plan
- Reset: hold `rst` 2 cycles mid-idle → all outputs at reset values; `in_ready`=1 the cycle after `rst` falls.
- Loopback, 4-stage SISO attached, `in_data`=4'b0110: `si` sequence 0,1,1,0 then 0,0,0,0. `out_valid` 8 cycles after accept, `out_data`=4'b0110, `err`=0, `err_cnt`=0.
- Corrupted loopback (`so_last` inverted), `in_data`=4'b1010: `out_data`=4'b0101, `err`=1, `err_cnt`=1.
- Backpressure: `out_ready`=0 for 5 cycles after `out_valid` → `out_data`/`err` stable, `in_ready`=0. A pulse of `in_valid` with 4'b1111 during this window is ignored. The next accepted word is processed normally.
- Reset mid-SHIFT (after 2 bits): no `out_valid`, state IDLE, `err_cnt`=0. A following word 4'b1001 loops back correctly.
- Saturation: 300 words with inverted tail → `err_cnt` reaches 255 and stays at 255.
